// File: rtl/moving_sum_multi.sv
// moving_sum_multi: per-channel sliding-window sum over the last N accepted samples, N runtime-programmable.
// Optional output saturation is enabled by defining MSUM_SAT_EN; otherwise the output wraps.
module moving_sum_multi #(
    parameter int NCH       = 3,
    parameter int WL_IN     = 20,
    parameter int WL_OUT    = 24,
    parameter int LMAX      = 32,
    parameter int L_DEFAULT = 16,
    parameter int WLW       = $clog2(LMAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_load,
    input  logic [WLW-1:0]          win_len,
    input  logic                    in_valid,
    input  logic [NCH*WL_IN-1:0]    data_in,
    output logic                    out_valid,
    output logic [NCH*WL_OUT-1:0]   sum_out,
    output logic                    win_full,
    output logic [WLW-1:0]          cur_len,
    output logic [NCH-1:0]          sat_flag
);

    localparam int ACCW = WL_IN + $clog2(LMAX);
    localparam int PW   = $clog2(LMAX);
    localparam logic [WLW-1:0] LMAX_W = WLW'(LMAX);
    localparam logic [WLW-1:0] LDEF_W = WLW'(L_DEFAULT);
    localparam logic [WLW-1:0] ONE_W  = WLW'(1);
`ifdef MSUM_SAT_EN
    localparam int EW = ((ACCW > WL_OUT) ? ACCW : WL_OUT) + 1;
    localparam logic [WL_OUT-1:0] SAT_MAX = {1'b0, {(WL_OUT-1){1'b1}}};
    localparam logic [WL_OUT-1:0] SAT_MIN = {1'b1, {(WL_OUT-1){1'b0}}};
`endif

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [WLW-1:0]         ptr_q, ptr_d;
    logic [WLW-1:0]         cnt_q, cnt_d;
    logic [WLW-1:0]         len_q, len_d;
    logic signed [ACCW-1:0] acc_q [NCH];
    logic signed [ACCW-1:0] acc_d [NCH];
    logic                   out_valid_q, out_valid_d;
    logic                   win_full_q, win_full_d;
    logic [NCH*WL_OUT-1:0]  sum_q, sum_d;
    logic [NCH-1:0]         sat_q, sat_d;

    logic [WL_IN-1:0]       ram_q [NCH][LMAX];
    logic                   ram_we;
    logic [PW-1:0]          wr_addr;

    logic [WLW-1:0]         len_clamp, len_eff, ptr_base, cnt_base, cnt_inc;
    logic                   run_eff;
    logic signed [ACCW-1:0] x_ext   [NCH];
    logic signed [ACCW-1:0] old_ext [NCH];
    logic signed [ACCW-1:0] acc_base;
`ifdef MSUM_SAT_EN
    logic [EW-1:0]          acc_ext;
`endif

    // Sign-extended new samples and the pre-write ring entries they replace.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            x_ext[k]   = ACCW'($signed(data_in[k*WL_IN +: WL_IN]));
            old_ext[k] = ACCW'($signed(ram_q[k][ptr_q[PW-1:0]]));
        end
    end

    always_comb begin
        if (win_len == '0) begin
            len_clamp = ONE_W;
        end else if (win_len > LMAX_W) begin
            len_clamp = LMAX_W;
        end else begin
            len_clamp = win_len;
        end
    end

    // A cfg_load restarts the window; a sample arriving with it is evaluated against the fresh state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = 1'b0;
        win_full_d  = win_full_q;
        sum_d       = sum_q;
        sat_d       = sat_q;
        ram_we      = 1'b0;
        acc_base    = '0;
        for (int k = 0; k < NCH; k++) begin
            acc_d[k] = acc_q[k];
        end
`ifdef MSUM_SAT_EN
        acc_ext = '0;
`endif

        len_eff  = cfg_load ? len_clamp : len_q;
        ptr_base = cfg_load ? '0 : ptr_q;
        cnt_base = cfg_load ? '0 : cnt_q;
        cnt_inc  = cnt_base + ONE_W;
        run_eff  = !cfg_load && (state_q == S_RUN);
        wr_addr  = ptr_base[PW-1:0];

        if (cfg_load) begin
            len_d   = len_clamp;
            ptr_d   = '0;
            cnt_d   = '0;
            state_d = S_FILL;
            for (int k = 0; k < NCH; k++) begin
                acc_d[k] = '0;
            end
        end

        if (in_valid && !rst) begin
            ram_we      = 1'b1;
            out_valid_d = 1'b1;
            ptr_d       = (ptr_base == len_eff - ONE_W) ? '0 : ptr_base + ONE_W;
            if (!run_eff) begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_eff) begin
                    state_d = S_RUN;
                end
            end
            win_full_d = run_eff || (cnt_inc == len_eff);
            for (int k = 0; k < NCH; k++) begin
                acc_base = cfg_load ? '0 : acc_q[k];
                acc_d[k] = run_eff ? (acc_base + x_ext[k] - old_ext[k]) : (acc_base + x_ext[k]);
`ifdef MSUM_SAT_EN
                acc_ext = EW'(acc_d[k]);
                if ((&acc_ext[EW-1:WL_OUT-1]) || (~|acc_ext[EW-1:WL_OUT-1])) begin
                    sum_d[k*WL_OUT +: WL_OUT] = acc_ext[WL_OUT-1:0];
                    sat_d[k] = 1'b0;
                end else begin
                    sum_d[k*WL_OUT +: WL_OUT] = acc_ext[EW-1] ? SAT_MIN : SAT_MAX;
                    sat_d[k] = 1'b1;
                end
`else
                sum_d[k*WL_OUT +: WL_OUT] = WL_OUT'(acc_d[k]);
                sat_d[k] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            ptr_q       <= '0;
            cnt_q       <= '0;
            len_q       <= LDEF_W;
            out_valid_q <= 1'b0;
            win_full_q  <= 1'b0;
            sum_q       <= '0;
            sat_q       <= '0;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            win_full_q  <= win_full_d;
            sum_q       <= sum_d;
            sat_q       <= sat_d;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    // Ring storage carries no reset; stale contents are always overwritten during FILL before being read.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < NCH; k++) begin
                ram_q[k][wr_addr] <= data_in[k*WL_IN +: WL_IN];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum_out   = sum_q;
    assign win_full  = win_full_q;
    assign cur_len   = len_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_moving_sum_multi.sv
// Scoreboard bench for moving_sum_multi: a queue-based window model predicts every output update.
module tb_moving_sum_multi;
    localparam int NCH = 3, WL_IN = 20, WL_OUT = 24, LMAX = 32, L_DEFAULT = 16;
    localparam int WLW = $clog2(LMAX + 1);

    typedef struct packed {
        logic [NCH*WL_OUT-1:0] s;
        logic                  wf;
        logic [NCH-1:0]        sat;
    } exp_t;

    logic clk, rst, cfg_load, in_valid;
    logic [WLW-1:0] win_len;
    logic [NCH*WL_IN-1:0] data_in;
    logic out_valid, win_full;
    logic [NCH*WL_OUT-1:0] sum_out;
    logic [WLW-1:0] cur_len;
    logic [NCH-1:0] sat_flag;

    int total = 0;
    int bad = 0;
    int n_model = L_DEFAULT;
    logic [NCH*WL_IN-1:0] hist[$];
    exp_t expq[$];
    exp_t hold;

    moving_sum_multi #(.NCH(NCH), .WL_IN(WL_IN), .WL_OUT(WL_OUT), .LMAX(LMAX), .L_DEFAULT(L_DEFAULT)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .win_len(win_len), .in_valid(in_valid),
        .data_in(data_in), .out_valid(out_valid), .sum_out(sum_out), .win_full(win_full),
        .cur_len(cur_len), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint dut_sum(input int k);
        return longint'($signed(sum_out[k*WL_OUT +: WL_OUT]));
    endfunction

    function automatic longint exp_sum(input exp_t e, input int k);
        return longint'($signed(e.s[k*WL_OUT +: WL_OUT]));
    endfunction

    function automatic logic [NCH*WL_IN-1:0] pk(input int a, input int b, input int c);
        logic [WL_IN-1:0] ea, eb, ec;
        ea = a[WL_IN-1:0];
        eb = b[WL_IN-1:0];
        ec = c[WL_IN-1:0];
        return {ec, eb, ea};
    endfunction

    // Reference: sum of the most recent min(accepts, N) samples, then wrap or clamp to WL_OUT.
    function automatic exp_t model_push(input logic [NCH*WL_IN-1:0] d);
        exp_t e;
        longint acc, maxv, minv;
        logic [63:0] bits;
        hist.push_back(d);
        if (hist.size() > n_model) void'(hist.pop_front());
        maxv = (64'sd1 <<< (WL_OUT - 1)) - 1;
        minv = -(64'sd1 <<< (WL_OUT - 1));
        e = '0;
        for (int k = 0; k < NCH; k++) begin
            acc = 0;
            foreach (hist[i]) acc += longint'($signed(hist[i][k*WL_IN +: WL_IN]));
`ifdef MSUM_SAT_EN
            if (acc > maxv) begin acc = maxv; e.sat[k] = 1'b1; end
            else if (acc < minv) begin acc = minv; e.sat[k] = 1'b1; end
`endif
            bits = acc;
            e.s[k*WL_OUT +: WL_OUT] = bits[WL_OUT-1:0];
        end
        e.wf = (hist.size() == n_model);
        return e;
    endfunction

    task automatic step(input logic v, input logic cl, input int wl, input logic [NCH*WL_IN-1:0] d);
        in_valid = v;
        cfg_load = cl;
        win_len  = WLW'(wl);
        data_in  = d;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            expq.delete();
            n_model = L_DEFAULT;
            hold = '0;
        end else begin
            if (cl) begin
                hist.delete();
                n_model = (wl == 0) ? 1 : ((wl > LMAX) ? LMAX : wl);
            end
            if (v) expq.push_back(model_push(d));
        end
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        chk("cur_len", longint'(cur_len), longint'(n_model));
    endtask

    // Monitor: pop on every presented update; between updates the outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    for (int k = 0; k < NCH; k++) begin
                        chk($sformatf("sum_ch%0d", k), dut_sum(k), exp_sum(e, k));
                    end
                    chk("win_full", longint'(win_full), longint'(e.wf));
                    chk("sat_flag", longint'(sat_flag), longint'(e.sat));
                    hold = e;
                end
            end else if (!rst) begin
                for (int k = 0; k < NCH; k++) begin
                    chk($sformatf("hold_sum_ch%0d", k), dut_sum(k), exp_sum(hold, k));
                end
                chk("hold_win_full", longint'(win_full), longint'(hold.wf));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; win_len = '0; data_in = '0;
        hold = '0;
        do_reset();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_sum", longint'(sum_out), 0);
        chk("rst_win_full", longint'(win_full), 0);
        chk("rst_cur_len", longint'(cur_len), L_DEFAULT);

        // Ramp on ch2, constants on ch0/ch1, default N=16.
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 0, pk(1, -1, k));
            if (k == 15) chk("ramp_wf15", longint'(win_full), 0);
            if (k == 16) begin
                chk("ramp16_ch0", dut_sum(0), 16);
                chk("ramp16_ch1", dut_sum(1), -16);
                chk("ramp16_ch2", dut_sum(2), 136);
                chk("ramp16_wf", longint'(win_full), 1);
            end
            if (k == 20) chk("ramp20_ch2", dut_sum(2), 200);
        end

        // Gapped input: 1 on, 2 off.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 0, pk(5, 0, 0));
            step(0, 0, 0, pk(9, 9, 9));
            chk("gap_out_valid", longint'(out_valid), 0);
            step(0, 0, 0, '0);
            if (k == 16 || k == 20) chk("gap_ch0", dut_sum(0), 80);
        end

        // Window shrink with a coincident sample.
        do_reset();
        for (int k = 0; k < 16; k++) step(1, 0, 0, pk(7, 7, 7));
        step(1, 1, 4, pk(7, 7, 7));
        chk("cfg_first_sum", dut_sum(0), 7);
        chk("cfg_first_wf", longint'(win_full), 0);
        chk("cfg_cur_len", longint'(cur_len), 4);
        for (int k = 0; k < 5; k++) step(1, 0, 0, pk(7, 7, 7));
        chk("cfg_steady_sum", dut_sum(0), 28);
        chk("cfg_steady_wf", longint'(win_full), 1);

        // Clamping of win_len.
        step(1, 1, 0, pk(3, 3, 3));
        chk("n1_sum_a", dut_sum(0), 3);
        chk("n1_wf_a", longint'(win_full), 1);
        step(1, 0, 0, pk(-9, -9, -9));
        chk("n1_sum_b", dut_sum(0), -9);
        chk("n1_wf_b", longint'(win_full), 1);
        step(0, 1, 40, '0);
        chk("clamp_cur_len", longint'(cur_len), 32);

        // Full-scale positive input over a 32-deep window.
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            step(1, (k == 1), 32, pk(524287, 524287, 524287));
            if (k == 17) begin
`ifdef MSUM_SAT_EN
                chk("fs17_sum", dut_sum(0), 8388607);
                chk("fs17_sat", longint'(sat_flag[0]), 1);
`else
                chk("fs17_sum", dut_sum(0), -7864337);
                chk("fs17_sat", longint'(sat_flag[0]), 0);
`endif
            end
        end

        // Reset mid-window with a sample in flight.
        do_reset();
        for (int k = 0; k < 10; k++) step(1, 0, 0, pk(5, 5, 5));
        rst = 1'b1;
        step(1, 0, 0, pk(5, 5, 5));
        rst = 1'b0;
        chk("midrst_out_valid", longint'(out_valid), 0);
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0, pk(5, 5, 5));
            chk("midrst_sum", dut_sum(1), 5 * k);
            chk("midrst_wf", longint'(win_full), 0);
        end

        // Randomized traffic with occasional reconfiguration and reset.
        for (int i = 0; i < 1500; i++) begin
            r = {$urandom(), $urandom()};
            rst = ($urandom_range(0, 199) == 0);
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 40)), r[NCH*WL_IN-1:0]);
            rst = 1'b0;
        end

        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("queue_drained", longint'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/moving_sum_multi.md
# moving_sum_multi

Multi-channel sliding-window accumulator for the timing-sync datapath. It sits between the correlator/energy stage and the metric/peak detector. Each of NCH signed input channels is summed over the most recent N accepted samples. N is a runtime-programmable window length up to LMAX, and the block flags when the window is fully populated. An optional output saturation stage is available.

## Interface
- NCH, 3: number of independent channels
- WL_IN, 20: signed input sample width per channel
- WL_OUT, 24: signed output sum width per channel
- LMAX, 32: maximum window depth; ring storage per channel; ≥2
- L_DEFAULT, 16: window length after reset; 1..LMAX
- WLW, $clog2(LMAX+1): width of window-length fields (derived)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_load  in  1  one-cycle strobe: adopt win_len and restart window
- win_len  in  WLW  requested window length N
- in_valid  in  1  sample strobe; one sample per channel accepted when high
- data_in  in  NCH*WL_IN  packed samples; channel k at [k*WL_IN +: WL_IN]
- out_valid  out  1  sum update strobe
- sum_out  out  NCH*WL_OUT  packed sums; channel k at [k*WL_OUT +: WL_OUT]
- win_full  out  1  presented sums cover exactly N samples
- cur_len  out  WLW  active window length
- sat_flag  out  NCH  per-channel saturation indicator for presented sum

## Operation
- Internal accumulator width ACCW = WL_IN + $clog2(LMAX). It never overflows internally.
- Per channel: ring RAM of depth LMAX, one shared write pointer ptr (0..N-1, wraps at N-1), and one shared fill count cnt (0..N).
- Two states:
  - FILL (cnt < N): on accept, acc += x, cnt++, ptr++. The old slot is not subtracted. Move to RUN when cnt reaches N.
  - RUN: on accept, acc += x − ram[ptr], ram[ptr] <= x, ptr advances.
- The read of ram[ptr] uses the pre-write value, which is the sample accepted exactly N accepts earlier.
- cfg_load:
  - Clamping: win_len=0 → N=1; win_len>LMAX → N=LMAX.
  - Effect: ptr=0, cnt=0, acc=0, state FILL. RAM contents are ignored.
  - cfg_load together with in_valid in the same cycle: the new N applies, and that sample becomes the first sample of the new window (acc=x, cnt=1, ptr=1). If N=1, ptr becomes 0 instead.
- N=1: sum_out equals the latest sample, and win_full=1 from the first accept.
- in_valid low: no state change, and outputs hold.
- Output conversion: without the macro, the low WL_OUT bits of acc (two's-complement wrap).
- rst mid-operation: everything returns to reset values on the next edge. Any in-flight sample is discarded.

## Timing
- Latency 1: a sample accepted on edge t produces out_valid=1 and an updated sum_out/win_full/sat_flag after edge t, visible during cycle t+1.
- out_valid is high one cycle per accepted sample and is never asserted without an accept.
- Back-to-back in_valid is supported: throughput is 1 sample/cycle, with no backpressure.
- win_full=1 on the output of the N-th accept after reset/cfg_load, and on every accept after that.
- cur_len updates one cycle after cfg_load.
- Reset values: out_valid=0, sum_out=0, win_full=0, sat_flag=0, cur_len=L_DEFAULT, ptr=0, cnt=0, acc=0.

## Configuration
- MSUM_SAT_EN defined:
  - Each acc is clamped to [−2^(WL_OUT−1), 2^(WL_OUT−1)−1] before output.
  - sat_flag[k]=1 when clamping occurred for that update.
  - The extra compare adds no latency.
- MSUM_SAT_EN undefined: the output wraps, and sat_flag is tied to 0.

## Test plan
- Reset then 20 accepts of ch0=1, ch1=−1, ch2=k (the accept index k=1..20), N=16 → at output 16 the sums are 16/−16/136 with win_full rising. At output 20 the sums are 16/−16/200.
- Gapped in_valid (1 on, 2 off, repeated) with ch0=+5 constant, N=16 → out_valid only follows accepts, sums hold during gaps, and the sum saturates at 80 after 16 accepts.
- After 16 accepts, cfg_load with win_len=4 while in_valid=1 and x=7 → next output sum=7, win_full=0, cur_len=4. Three more accepts of 7 give 28 with win_full=1, and it then stays at 28.
- Clamping:
  - win_len=0 with x=3,−9 → outputs 3 then −9, win_full=1 each time.
  - win_len=40 → cur_len=32.
- WL_IN=20, N=32, all channels +2^19−1 → with MSUM_SAT_EN the output is 2^23−1 and sat_flag=1 from accept 17. Without the macro, the output equals the wrapped low 24 bits and sat_flag=0.
- rst asserted mid-window (after 10 accepts of 5), then 3 accepts of 5 → outputs 5, 10, 15 with win_full=0. out_valid=0 during the reset cycle.
